// File: rtl/axis_capture_ram.sv
// AXI-Stream frame capture into block RAM with a registered random-access read port.
// A frame is armed with an expected length; tlast/length disagreements are flagged.
module axis_capture_ram #(
    parameter int G_AXI_DATAWIDTH  = 32,
    parameter int G_AXIS_DATAWIDTH = 32,
    parameter int G_MEMDEPTH       = 1024,
    parameter int G_ADDRWIDTH      = $clog2(G_MEMDEPTH),
    parameter int G_AXI_PACK       = G_AXIS_DATAWIDTH / G_AXI_DATAWIDTH,
    parameter int G_RADDRWIDTH     = G_ADDRWIDTH + $clog2(G_AXI_PACK)
) (
    input  logic                        s_aclk,
    input  logic                        s_areset,
    input  logic [G_AXIS_DATAWIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    input  logic                        arm,
    input  logic [G_ADDRWIDTH:0]        frame_length,
    output logic                        busy,
    output logic                        done,
    output logic                        err_early_last,
    output logic                        err_no_last,
    output logic [G_ADDRWIDTH:0]        beat_cnt,
    input  logic                        rd,
    input  logic [G_RADDRWIDTH-1:0]     raddr,
    output logic [G_AXI_DATAWIDTH-1:0]  rdata,
    output logic                        rvalid
);

    localparam int                   LANE_W  = $clog2(G_AXI_PACK);
    localparam logic [G_ADDRWIDTH:0] MAX_LEN = (G_ADDRWIDTH+1)'(G_MEMDEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t                      state, state_nxt;
    logic [G_ADDRWIDTH:0]        len_q;
    logic [G_ADDRWIDTH:0]        cnt_inc;
    logic                        accept, arm_ok;
    logic                        start, wr_en, set_early, set_nolast;
    logic [G_AXIS_DATAWIDTH-1:0] mem [G_MEMDEPTH];
    logic [G_ADDRWIDTH-1:0]      rbeat;
    logic [G_AXIS_DATAWIDTH-1:0] rword;
    logic [G_AXI_DATAWIDTH-1:0]  rlane_data;
    logic [G_AXI_DATAWIDTH-1:0]  rdata_p1;
    logic                        vld_p1;

    // Requested lengths beyond the memory are clipped to its depth.
    function automatic logic [G_ADDRWIDTH:0] sat_len(input logic [G_ADDRWIDTH:0] req);
        return (req > MAX_LEN) ? MAX_LEN : req;
    endfunction

    assign accept  = s_axis_tvalid & s_axis_tready;
    assign arm_ok  = arm & (frame_length != '0);
    assign cnt_inc = beat_cnt + 1'b1;

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        wr_en      = 1'b0;
        set_early  = 1'b0;
        set_nolast = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (arm_ok) begin
                    state_nxt = S_CAPTURE;
                    start     = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (s_axis_tlast) begin
                        state_nxt = S_DONE;
                        set_early = (cnt_inc < len_q);
                    end else if (cnt_inc == len_q) begin
                        state_nxt  = S_DRAIN;
                        set_nolast = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && s_axis_tlast) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            state          <= S_IDLE;
            s_axis_tready  <= 1'b0;
            len_q          <= '0;
            beat_cnt       <= '0;
            err_early_last <= 1'b0;
            err_no_last    <= 1'b0;
        end else begin
            state         <= state_nxt;
            s_axis_tready <= (state_nxt == S_CAPTURE) || (state_nxt == S_DRAIN);
            if (start) begin
                len_q          <= sat_len(frame_length);
                beat_cnt       <= '0;
                err_early_last <= 1'b0;
                err_no_last    <= 1'b0;
            end else begin
                if (wr_en)      beat_cnt       <= cnt_inc;
                if (set_early)  err_early_last <= 1'b1;
                if (set_nolast) err_no_last    <= 1'b1;
            end
        end
    end

    assign busy = (state == S_CAPTURE) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    // The beat counter doubles as the write pointer; it stops at the latched length.
    always_ff @(posedge s_aclk) begin
        if (wr_en) mem[beat_cnt[G_ADDRWIDTH-1:0]] <= s_axis_tdata;
    end

    assign rbeat = raddr[G_RADDRWIDTH-1 -: G_ADDRWIDTH];
    assign rword = mem[rbeat];

    generate
        if (LANE_W == 0) begin : gen_nolane
            assign rlane_data = rword;
        end else begin : gen_lane
            logic [LANE_W-1:0] rlane;
            assign rlane      = raddr[LANE_W-1:0];
            assign rlane_data = rword[rlane*G_AXI_DATAWIDTH +: G_AXI_DATAWIDTH];
        end
    endgenerate

    // Read stage p1: registered word, old data wins on a same-beat write.
    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= rd;
            if (rd) rdata_p1 <= rlane_data;
        end
    end

    assign rdata  = rdata_p1;
    assign rvalid = vld_p1;

endmodule

// File: tb/tb_axis_capture_ram.sv
// Directed self-checking bench for axis_capture_ram: a 32-bit instance (depth 16)
// and a 64-bit stream / 32-bit read instance for lane packing.
module tb_axis_capture_ram;

    logic        clk;
    logic        rst;

    logic [31:0] tdata;
    logic        tvalid, tlast, tready;
    logic        arm;
    logic [4:0]  flen;
    logic        busy, done, ee, enl;
    logic [4:0]  bcnt;
    logic        rd;
    logic [3:0]  raddr;
    logic [31:0] rdata;
    logic        rvalid;

    logic [63:0] p_tdata;
    logic        p_tvalid, p_tlast, p_tready;
    logic        p_arm;
    logic [4:0]  p_flen;
    logic        p_busy, p_done, p_ee, p_enl;
    logic [4:0]  p_bcnt;
    logic        p_rd;
    logic [4:0]  p_raddr;
    logic [31:0] p_rdata;
    logic        p_rvalid;

    int tests = 0;
    int fails = 0;

    axis_capture_ram #(
        .G_AXI_DATAWIDTH(32), .G_AXIS_DATAWIDTH(32), .G_MEMDEPTH(16)
    ) dut (
        .s_aclk(clk), .s_areset(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
        .s_axis_tready(tready),
        .arm(arm), .frame_length(flen),
        .busy(busy), .done(done), .err_early_last(ee), .err_no_last(enl),
        .beat_cnt(bcnt),
        .rd(rd), .raddr(raddr), .rdata(rdata), .rvalid(rvalid)
    );

    axis_capture_ram #(
        .G_AXI_DATAWIDTH(32), .G_AXIS_DATAWIDTH(64), .G_MEMDEPTH(16)
    ) dut_p (
        .s_aclk(clk), .s_areset(rst),
        .s_axis_tdata(p_tdata), .s_axis_tvalid(p_tvalid), .s_axis_tlast(p_tlast),
        .s_axis_tready(p_tready),
        .arm(p_arm), .frame_length(p_flen),
        .busy(p_busy), .done(p_done), .err_early_last(p_ee), .err_no_last(p_enl),
        .beat_cnt(p_bcnt),
        .rd(p_rd), .raddr(p_raddr), .rdata(p_rdata), .rvalid(p_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic arm_t(input logic [4:0] len);
        arm  = 1'b1;
        flen = len;
        tick();
        arm  = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        logic acc;
        int   n;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        n      = 0;
        acc    = 1'b0;
        while (!acc && n < 20) begin
            acc = tready;
            tick();
            n++;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        chk($sformatf("accept_%0h", d), {63'd0, acc}, 64'd1);
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [31:0] e);
        rd    = 1'b1;
        raddr = a;
        tick();
        rd    = 1'b0;
        chk($sformatf("rvalid_%0d", a), {63'd0, rvalid}, 64'd1);
        chk($sformatf("rdata_%0d", a), {32'd0, rdata}, {32'd0, e});
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    initial begin
        rst = 1'b1;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0; arm = 1'b0; flen = '0; rd = 1'b0; raddr = '0;
        p_tdata = '0; p_tvalid = 1'b0; p_tlast = 1'b0; p_arm = 1'b0; p_flen = '0;
        p_rd = 1'b0; p_raddr = '0;
        repeat (3) tick();
        chk("rst_tready", {63'd0, tready}, 64'd0);
        chk("rst_busy",   {63'd0, busy},   64'd0);
        chk("rst_done",   {63'd0, done},   64'd0);
        chk("rst_errs",   {62'd0, ee, enl}, 64'd0);
        chk("rst_bcnt",   {59'd0, bcnt},   64'd0);
        chk("rst_rdata",  {32'd0, rdata},  64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        rst = 1'b0;
        tick();

        // zero-length arm is ignored
        arm_t(5'd0);
        tick();
        chk("zlen_busy",   {63'd0, busy},   64'd0);
        chk("zlen_tready", {63'd0, tready}, 64'd0);

        // basic capture with gaps and an ignored mid-capture arm
        arm_t(5'd8);
        chk("basic_tready", {63'd0, tready}, 64'd1);
        chk("basic_busy",   {63'd0, busy},   64'd1);
        for (int i = 0; i < 8; i++) begin
            send(32'h100 + i, i == 7);
            if (i == 3) begin
                arm_t(5'd2);
                chk("midarm_busy", {63'd0, busy}, 64'd1);
                chk("midarm_bcnt", {59'd0, bcnt}, 64'd4);
            end
            if (i != 7) gap();
        end
        chk("basic_done",   {63'd0, done},   64'd1);
        chk("basic_bcnt",   {59'd0, bcnt},   64'd8);
        chk("basic_errs",   {62'd0, ee, enl}, 64'd0);
        chk("basic_tready0", {63'd0, tready}, 64'd0);
        chk("basic_busy0",  {63'd0, busy},   64'd0);
        for (int i = 0; i < 8; i++) rd_chk(4'(i), 32'h100 + i);
        tick();
        chk("rvalid_drop", {63'd0, rvalid}, 64'd0);
        chk("rdata_hold",  {32'd0, rdata},  64'h107);

        // lane packing on the 64-bit instance
        p_arm = 1'b1; p_flen = 5'd2;
        tick();
        p_arm = 1'b0;
        chk("pack_tready", {63'd0, p_tready}, 64'd1);
        p_tvalid = 1'b1; p_tdata = 64'h11112222_33334444;
        tick();
        p_tdata = 64'hAAAABBBB_CCCCDDDD; p_tlast = 1'b1;
        tick();
        p_tvalid = 1'b0; p_tlast = 1'b0;
        chk("pack_done", {63'd0, p_done}, 64'd1);
        chk("pack_bcnt", {59'd0, p_bcnt}, 64'd2);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] pexp [4];
            pexp[0] = 32'h33334444; pexp[1] = 32'h11112222;
            pexp[2] = 32'hCCCCDDDD; pexp[3] = 32'hAAAABBBB;
            p_rd = 1'b1; p_raddr = 5'(i);
            tick();
            p_rd = 1'b0;
            chk($sformatf("pack_rvalid_%0d", i), {63'd0, p_rvalid}, 64'd1);
            chk($sformatf("pack_rdata_%0d", i), {32'd0, p_rdata}, {32'd0, pexp[i]});
        end

        // early tlast
        arm_t(5'd8);
        chk("early_done_clr", {63'd0, done}, 64'd0);
        for (int i = 0; i < 5; i++) send(32'h200 + i, i == 4);
        chk("early_err",    {63'd0, ee},     64'd1);
        chk("early_nolast", {63'd0, enl},    64'd0);
        chk("early_done",   {63'd0, done},   64'd1);
        chk("early_bcnt",   {59'd0, bcnt},   64'd5);
        chk("early_tready", {63'd0, tready}, 64'd0);

        // missing tlast: extra beats are drained, not written
        arm_t(5'd4);
        chk("nolast_errclr", {63'd0, ee}, 64'd0);
        for (int i = 0; i < 4; i++) send(32'h300 + i, 1'b0);
        chk("nolast_err",    {63'd0, enl},    64'd1);
        chk("nolast_drain",  {63'd0, busy},   64'd1);
        chk("nolast_tready", {63'd0, tready}, 64'd1);
        chk("nolast_notdone", {63'd0, done},  64'd0);
        send(32'h304, 1'b0);
        send(32'h305, 1'b1);
        chk("nolast_done", {63'd0, done}, 64'd1);
        chk("nolast_bcnt", {59'd0, bcnt}, 64'd4);
        chk("nolast_ee",   {63'd0, ee},   64'd0);
        rd_chk(4'd3, 32'h303);
        rd_chk(4'd4, 32'h204);
        rd_chk(4'd5, 32'h105);

        // reset mid-frame keeps memory, clears control
        arm_t(5'd8);
        for (int i = 0; i < 3; i++) send(32'h400 + i, 1'b0);
        rst = 1'b1;
        tick();
        chk("mrst_tready", {63'd0, tready}, 64'd0);
        chk("mrst_busy",   {63'd0, busy},   64'd0);
        chk("mrst_done",   {63'd0, done},   64'd0);
        chk("mrst_errs",   {62'd0, ee, enl}, 64'd0);
        chk("mrst_bcnt",   {59'd0, bcnt},   64'd0);
        chk("mrst_rdata",  {32'd0, rdata},  64'd0);
        chk("mrst_rvalid", {63'd0, rvalid}, 64'd0);
        rst = 1'b0;
        tick();
        rd_chk(4'd1, 32'h401);
        rd_chk(4'd3, 32'h303);

        // re-arm; first beat write coincides with a read of the same beat
        arm_t(5'd8);
        chk("rearm_tready", {63'd0, tready}, 64'd1);
        tdata = 32'h500; tvalid = 1'b1; tlast = 1'b0; rd = 1'b1; raddr = 4'd0;
        tick();
        tvalid = 1'b0; rd = 1'b0;
        chk("rfirst_rdata", {32'd0, rdata}, 64'h400);
        chk("rfirst_bcnt",  {59'd0, bcnt},  64'd1);
        for (int i = 1; i < 8; i++) begin
            send(32'h500 + i, i == 7);
            gap();
        end
        chk("rearm_done", {63'd0, done}, 64'd1);
        chk("rearm_bcnt", {59'd0, bcnt}, 64'd8);
        chk("rearm_errs", {62'd0, ee, enl}, 64'd0);
        rd_chk(4'd0, 32'h500);
        rd_chk(4'd7, 32'h507);

        // length beyond depth saturates at 16
        arm_t(5'd20);
        for (int i = 0; i < 16; i++) send(32'h600 + i, 1'b0);
        chk("sat_bcnt",  {59'd0, bcnt}, 64'd16);
        chk("sat_nolast", {63'd0, enl}, 64'd1);
        chk("sat_busy",  {63'd0, busy}, 64'd1);
        send(32'h6FF, 1'b1);
        chk("sat_done",  {63'd0, done}, 64'd1);
        chk("sat_bcnt2", {59'd0, bcnt}, 64'd16);
        rd_chk(4'd15, 32'h60F);
        rd_chk(4'd0,  32'h600);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
